// File: rtl/instr_sequencer.sv
// instr_sequencer
//   Plays a small loaded program out to a processor, one instruction word at a
//   time, each word held for HOLD cycles. Entries are loaded while idle; a run
//   walks entries 0..prog_len-1, either once (ending in a one-cycle DONE) or
//   wrapping forever in repeat mode until stop/rst.
//
// Ports
//   clk, rst                 clock (rising edge), synchronous active-high reset
//   ld_valid/ld_addr/
//   ld_opcode/ld_data        program-load write port (accepted only in IDLE)
//   start, stop              begin / abort execution
//   prog_len, repeat_mode    run length (1..16) and wrap enable, sampled on start
//   opcode, data             presented instruction word and operand
//   issue                    high on the first cycle of each presented word
//   pc                       index of the presented word
//   ld_ready, busy, done,err IDLE / RUN / completion pulse / error pulse
module instr_sequencer #(
  parameter int HOLD  = 4,
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ld_valid,
  input  logic [3:0] ld_addr,
  input  logic [9:0] ld_opcode,
  input  logic [4:0] ld_data,
  input  logic       start,
  input  logic       stop,
  input  logic [4:0] prog_len,
  input  logic       repeat_mode,
  output logic [9:0] opcode,
  output logic [4:0] data,
  output logic       issue,
  output logic [3:0] pc,
  output logic       ld_ready,
  output logic       busy,
  output logic       done,
  output logic       err
);

  // op 1, source 0, destination 7: a word that writes no register
  localparam logic [9:0] IDLE_OP = 10'h047;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  pc_q, pc_d;
  logic [3:0]  cnt_q, cnt_d;     // cycles already spent on the current word
  logic [4:0]  len_q, len_d;
  logic        rep_q, rep_d;
  logic        err_q, err_d;
  logic [14:0] mem_q [DEPTH];    // {opcode, data}; deliberately never reset

  logic ld_legal, ld_we, len_ok, last_hold, last_entry;

  assign ld_legal   = (ld_opcode[9:6] <= 4'd12) && (ld_opcode[5:3] <= 3'd5) &&
                      (ld_opcode[2:0] <= 3'd4);
  assign len_ok     = (prog_len != 5'd0) && (prog_len <= 5'd16);
  assign ld_we      = !rst && (state_q == IDLE) && ld_valid && ld_legal &&
                      (int'(ld_addr) < DEPTH);
  assign last_hold  = (cnt_q == 4'(HOLD - 1));
  assign last_entry = ({1'b0, pc_q} == (len_q - 5'd1));

  always_ff @(posedge clk) begin
    if (ld_we) mem_q[ld_addr] <= {ld_opcode, ld_data};
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    rep_d   = rep_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (ld_valid && !ld_legal) err_d = 1'b1;
        // stop beats start: a simultaneous pair is simply ignored
        if (start && !stop) begin
          if (len_ok) begin
            state_d = RUN;
            pc_d    = 4'd0;
            cnt_d   = 4'd0;
            len_d   = prog_len;
            rep_d   = repeat_mode;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
          pc_d    = 4'd0;
          cnt_d   = 4'd0;
        end else if (last_hold) begin
          cnt_d = 4'd0;
          if (last_entry) begin
            pc_d = 4'd0;
            if (!rep_q) state_d = DONE;
          end else begin
            pc_d = pc_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= 4'd0;
      cnt_q   <= 4'd0;
      len_q   <= 5'd1;
      rep_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      rep_q   <= rep_d;
      err_q   <= err_d;
    end
  end

  assign busy     = (state_q == RUN);
  assign ld_ready = (state_q == IDLE);
  assign done     = (state_q == DONE);
  assign err      = err_q;
  assign issue    = busy && (cnt_q == 4'd0);
  assign pc       = pc_q;
  assign opcode   = busy ? mem_q[pc_q][14:5] : IDLE_OP;
  assign data     = busy ? mem_q[pc_q][4:0]  : 5'd0;

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: directed scenarios followed by random traffic,
// every cycle compared against a model that tracks a run as "cycles since
// start" and derives pc/issue/done arithmetically from it.
module tb_instr_sequencer;
  localparam int HOLD = 4;

  logic       clk = 1'b0;
  logic       rst, ld_valid, start, stop, repeat_mode;
  logic [3:0] ld_addr;
  logic [9:0] ld_opcode;
  logic [4:0] ld_data, prog_len;
  logic [9:0] opcode;
  logic [4:0] data;
  logic [3:0] pc;
  logic       issue, ld_ready, busy, done, err;

  always #5 clk = ~clk;

  instr_sequencer #(.HOLD(HOLD), .DEPTH(16)) dut (
    .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_addr(ld_addr),
    .ld_opcode(ld_opcode), .ld_data(ld_data), .start(start), .stop(stop),
    .prog_len(prog_len), .repeat_mode(repeat_mode), .opcode(opcode),
    .data(data), .issue(issue), .pc(pc), .ld_ready(ld_ready), .busy(busy),
    .done(done), .err(err)
  );

  int ncmp = 0, nfail = 0;

  // reference model state
  logic [14:0] mmem [16];
  bit m_run = 0, m_done = 0, m_err = 0, m_rep = 0;
  int m_t = 0, m_len = 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit legal(input logic [9:0] w);
    return (w[9:6] <= 4'd12) && (w[5:3] <= 3'd5) && (w[2:0] <= 3'd4);
  endfunction

  // One clock: advance the model with the inputs the DUT sampled, then compare.
  task automatic step();
    bit was_done;
    int epc;
    logic [14:0] w;
    @(posedge clk);
    was_done = m_done;
    m_done = 0;
    m_err  = 0;
    if (rst) begin
      m_run = 0;
    end else if (m_run) begin
      if (stop) m_run = 0;
      else begin
        m_t++;
        if (m_t == m_len * HOLD) begin
          if (m_rep) m_t = 0;
          else begin m_run = 0; m_done = 1; end
        end
      end
    end else if (!was_done) begin
      if (ld_valid) begin
        if (legal(ld_opcode)) mmem[ld_addr] = {ld_opcode, ld_data};
        else m_err = 1;
      end
      if (start && !stop) begin
        if (prog_len >= 1 && prog_len <= 16) begin
          m_run = 1; m_t = 0; m_len = int'(prog_len); m_rep = repeat_mode;
        end else m_err = 1;
      end
    end
    #1;
    epc = m_run ? (m_t / HOLD) : 0;
    w   = m_run ? mmem[epc] : {10'h047, 5'd0};
    chk("opcode",   32'(opcode),   32'(w[14:5]));
    chk("data",     32'(data),     32'(w[4:0]));
    chk("pc",       32'(pc),       32'(epc));
    chk("issue",    32'(issue),    32'(m_run && (m_t % HOLD == 0)));
    chk("busy",     32'(busy),     32'(m_run));
    chk("done",     32'(done),     32'(m_done));
    chk("err",      32'(err),      32'(m_err));
    chk("ld_ready", 32'(ld_ready), 32'(!m_run && !m_done));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic load(input logic [3:0] a, input logic [9:0] op, input logic [4:0] d);
    ld_valid = 1; ld_addr = a; ld_opcode = op; ld_data = d;
    step();
    ld_valid = 0;
  endtask

  task automatic go(input logic [4:0] len, input logic rep);
    start = 1; prog_len = len; repeat_mode = rep;
    step();
    start = 0;
  endtask

  function automatic logic [9:0] rand_legal();
    return {4'($urandom_range(0, 12)), 3'($urandom_range(0, 5)), 3'($urandom_range(0, 4))};
  endfunction

  initial begin
    rst = 1; ld_valid = 0; ld_addr = 0; ld_opcode = 0; ld_data = 0;
    start = 0; stop = 0; prog_len = 0; repeat_mode = 0;
    run(2);
    rst = 0;
    step();

    // fill every entry so no read touches an unloaded slot
    for (int i = 0; i < 16; i++) load(4'(i), rand_legal(), 5'($urandom));

    // 10'h04D has destination 5, so the load rule rejects it (err, no write)
    load(4'd0, 10'h04D, 5'd3);
    load(4'd1, 10'h0CA, 5'd0);
    load(4'd2, 10'h109, 5'd0);
    load(4'd0, 10'h04C, 5'd3);
    go(5'd3, 1'b0);
    run(16);

    // illegal op 13 at entry 5, then read entry 5 back through a run
    load(4'd5, 10'h340, 5'd9);
    go(5'd6, 1'b0);
    run(28);

    // repeat mode wrap, then abort with stop
    go(5'd2, 1'b1);
    run(5);
    stop = 1; step(); stop = 0;
    run(3);

    // bad lengths
    go(5'd0, 1'b0);
    go(5'd17, 1'b0);
    run(2);

    // reset mid-run, then rerun intact
    go(5'd3, 1'b0);
    run(6);
    rst = 1; step(); rst = 0;
    go(5'd3, 1'b0);
    run(14);

    // load during run ignored; start+stop together ignored; start while busy ignored
    go(5'd3, 1'b0);
    run(2);
    load(4'd0, 10'h000, 5'd1);
    go(5'd1, 1'b1);
    run(12);
    start = 1; stop = 1; prog_len = 5'd3; step(); start = 0; stop = 0;
    run(2);

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      rst         = ($urandom_range(0, 99) == 0);
      ld_valid    = ($urandom_range(0, 3) == 0);
      ld_addr     = 4'($urandom);
      ld_opcode   = ($urandom_range(0, 3) == 0) ? 10'($urandom) : rand_legal();
      ld_data     = 5'($urandom);
      start       = ($urandom_range(0, 9) == 0);
      stop        = ($urandom_range(0, 39) == 0);
      prog_len    = 5'($urandom_range(0, 18));
      repeat_mode = ($urandom_range(0, 2) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
